// File: rtl/bus_arbiter_4_if.sv
// Shared-bus handshake bundle between the four bus masters and the arbiter.
//   requestIn[3:0]      per-master request, bit i = master i
//   beginTransactionIn  wired-OR beginTransaction from the masters
//   endTransactionIn    wired-OR endTransaction from all agents
//   busErrorIn          busError from any agent
//   grantOut[3:0]       one-hot grant from the arbiter
//   endTransactionOut   arbiter-driven endTransaction (watchdog abort)
//   busErrorOut         arbiter-driven busError (watchdog abort)
// Modport master: the agent side, drives the requests and handshakes.
// Modport slave:  the arbiter side, drives the grant and abort signals.
interface bus_arbiter_4_if;
    logic [3:0] requestIn;
    logic       beginTransactionIn;
    logic       endTransactionIn;
    logic       busErrorIn;
    logic [3:0] grantOut;
    logic       endTransactionOut;
    logic       busErrorOut;

    modport master (
        output requestIn,
        output beginTransactionIn,
        output endTransactionIn,
        output busErrorIn,
        input  grantOut,
        input  endTransactionOut,
        input  busErrorOut
    );

    modport slave (
        input  requestIn,
        input  beginTransactionIn,
        input  endTransactionIn,
        input  busErrorIn,
        output grantOut,
        output endTransactionOut,
        output busErrorOut
    );
endinterface

// File: rtl/bus_arbiter_4.sv
// Round-robin arbiter for a four-master shared bus with start and
// transaction watchdogs.
//   clock   rising-edge clock
//   nReset  asynchronous active-low reset
//   bus     bus_arbiter_4_if.slave: requests/handshakes in, grant and
//           abort signalling out (all outputs registered)
// Parameters:
//   START_TIMEOUT  cycles a granted master has to begin (1..65535)
//   BUS_TIMEOUT    cycles a transaction may stay open (1..65535)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no grant; pick next requester round-robin
// GRANTED | grant held, waiting for beginTransaction or start timeout
// BUSY    | transaction open, waiting for end/error or bus timeout
// ABORT   | one cycle driving busErrorOut and endTransactionOut
module bus_arbiter_4 #(
    parameter int START_TIMEOUT = 16,
    parameter int BUS_TIMEOUT   = 1024
) (
    input  logic              clock,
    input  logic              nReset,
    bus_arbiter_4_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        BUSY    = 2'd2,
        ABORT   = 2'd3
    } state_t;

    localparam logic [15:0] START_LAST = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] BUS_LAST   = 16'(BUS_TIMEOUT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [1:0]  last_idx;
    logic [3:0]  grant_q;
    logic        end_q;
    logic        err_q;

    logic [1:0]  pick_idx;
    logic        pick_valid;
    logic [1:0]  cand;

    // Search starts one past the last grant; 2-bit add wraps naturally,
    // and k=4 lands back on last_idx so a lone requester can be regranted.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last_idx;
        cand       = last_idx;
        for (int k = 1; k <= 4; k++) begin
            cand = last_idx + 2'(k);
            if (!pick_valid && bus.requestIn[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            last_idx <= 2'd3;
            grant_q  <= 4'b0000;
            end_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    end_q <= 1'b0;
                    err_q <= 1'b0;
                    if (pick_valid) begin
                        grant_q  <= 4'b0001 << pick_idx;
                        last_idx <= pick_idx;
                        cnt      <= 16'd0;
                        state    <= GRANTED;
                    end
                end
                GRANTED: begin
                    // last_idx is the current owner while a grant is held.
                    if (bus.beginTransactionIn) begin
                        cnt   <= 16'd0;
                        state <= BUSY;
                    end else if (!bus.requestIn[last_idx] || cnt == START_LAST) begin
                        grant_q <= 4'b0000;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                BUSY: begin
                    if (bus.endTransactionIn || bus.busErrorIn) begin
                        grant_q <= 4'b0000;
                        state   <= IDLE;
                    end else if (cnt == BUS_LAST) begin
                        grant_q <= 4'b0000;
                        end_q   <= 1'b1;
                        err_q   <= 1'b1;
                        state   <= ABORT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ABORT: begin
                    end_q <= 1'b0;
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    grant_q <= 4'b0000;
                    end_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.grantOut          = grant_q;
    assign bus.endTransactionOut = end_q;
    assign bus.busErrorOut       = err_q;

endmodule

// File: doc/bus_arbiter_4.md
BUS_ARBITER_4 -- requirements
Module: bus_arbiter_4

Interface
REQ-001 Parameter: START_TIMEOUT, default 16, cycles a granted master may take to assert beginTransaction before its grant is withdrawn (legal 1..65535).
REQ-002 Parameter: BUS_TIMEOUT, default 1024, cycles a transaction may stay open before the watchdog aborts it (legal 1..65535).
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 nReset  input  1  reset, asynchronous and active-low.
REQ-005 requestIn  input  4  per-master bus request; bit i belongs to master i.
REQ-006 beginTransactionIn  input  1  shared-bus beginTransaction, OR of all masters.
REQ-007 endTransactionIn  input  1  shared-bus endTransaction, OR of all agents.
REQ-008 busErrorIn  input  1  shared-bus busError from any agent.
REQ-009 grantOut  output  4  registered one-hot grant; at most one bit set.
REQ-010 endTransactionOut  output  1  registered; arbiter-driven endTransaction on watchdog abort.
REQ-011 busErrorOut  output  1  registered; arbiter-driven busError on watchdog abort.

Function
REQ-012 The FSM SHALL have four states: IDLE, GRANTED, BUSY and ABORT.
REQ-013 IDLE with requestIn != 0 SHALL select one master by round-robin, set its grantOut bit on the next edge, enter GRANTED and clear the cycle counter.
REQ-014 Round-robin: search SHALL start at (last granted index + 1) mod 4, ascending with wrap; after reset the last granted index SHALL be 3, so master 0 has top priority.
REQ-015 The last granted index SHALL update only when a grant is issued.
REQ-016 GRANTED with beginTransactionIn=1 SHALL enter BUSY, keep grantOut, and clear the counter.
REQ-017 GRANTED with the granted request bit low and beginTransactionIn=0 SHALL clear grantOut and enter IDLE.
REQ-018 GRANTED with the counter = START_TIMEOUT-1 and no begin SHALL clear grantOut and enter IDLE; no error is signalled.
REQ-019 BUSY with endTransactionIn=1 or busErrorIn=1 SHALL clear grantOut and enter IDLE; requestIn is ignored in BUSY.
REQ-020 BUSY with the counter = BUS_TIMEOUT-1 and neither end nor error SHALL clear grantOut and enter ABORT.
REQ-021 In ABORT, busErrorOut and endTransactionOut SHALL be 1 for exactly one cycle, then the FSM SHALL enter IDLE.
REQ-022 If endTransactionIn and the timeout coincide in BUSY, end SHALL win: go to IDLE, no abort.
REQ-023 If beginTransactionIn and the start timeout coincide in GRANTED, begin SHALL win.
REQ-024 The counter SHALL be 16 bits, increment by 1 each cycle in GRANTED/BUSY, and never wrap before its timeout.
REQ-025 Every grant SHALL be preceded by at least one IDLE cycle with grantOut=0, so no two grants are adjacent.
REQ-026 beginTransactionIn seen in IDLE SHALL be ignored, with no state change.

Reset
REQ-027 nReset=0 SHALL immediately force IDLE, grantOut=0000, endTransactionOut=0, busErrorOut=0, counter=0 and last granted index=3, including mid-transaction.
REQ-028 After nReset deasserts, the first grant SHALL occur no earlier than the first rising edge with nReset=1.

Verification
REQ-029 Scenario: reset, then requestIn=1111 held -> grants 0001, 0010, 0100, 1000, 0001 in order, each ended by begin and then end pulses.
REQ-030 Scenario: requestIn=0100, grant, no begin for 16 cycles -> grantOut=0000 at cycle 16, busErrorOut stays 0.
REQ-031 Scenario: BUS_TIMEOUT=8, begin, no end -> after 8 BUSY cycles grantOut=0 and one cycle with busErrorOut=endTransactionOut=1, then IDLE.
REQ-032 Scenario: endTransactionIn on the same cycle the counter reaches BUS_TIMEOUT-1 -> IDLE, busErrorOut stays 0.
REQ-033 Scenario: nReset pulsed low during BUSY with grantOut=0010 -> grantOut=0000 asynchronously; next requestIn=1010 grants 0010 first (master 0 has no request, so master 1 is next in order).
REQ-034 Scenario: granted master drops its request before begin -> grant cleared next edge; a waiting master is granted after one idle cycle.
